// File: rtl/osf_pkg.sv
// Shared definitions for the order-statistics filter blocks.
// State encoding and odd-even transposition sort cost helpers.
package osf_pkg;

  localparam logic [1:0] ST_LOAD  = 2'd0;
  localparam logic [1:0] ST_SORT  = 2'd1;
  localparam logic [1:0] ST_DRAIN = 2'd2;
  localparam logic [1:0] ST_OUT   = 2'd3;

  typedef enum logic [1:0] {
    LOAD  = ST_LOAD,
    SORT  = ST_SORT,
    DRAIN = ST_DRAIN,
    OUT   = ST_OUT
  } state_e;

  function automatic int pairs_even(input int n);
    return n / 2;
  endfunction

  function automatic int pairs_odd(input int n);
    return (n - 1) / 2;
  endfunction

  // Every phase issues its pairs and then spends one drain cycle.
  function automatic int SORT_CYCLES(input int n);
    int s;
    s = 0;
    for (int p = 0; p < n; p++) begin
      s += ((p % 2 == 0) ? pairs_even(n) : pairs_odd(n)) + 1;
    end
    return s;
  endfunction

endpackage

// File: rtl/comparer2.sv
// Registered two-input compare-swap, latency one cycle.
// dout_lo gets the smaller input, dout_hi the larger.
module comparer2 #(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  arstn,
  input  logic [DATA_WIDTH-1:0] dinA,
  input  logic [DATA_WIDTH-1:0] dinB,
  output logic [DATA_WIDTH-1:0] dout_lo,
  output logic [DATA_WIDTH-1:0] dout_hi
);

  always_ff @(posedge clk or negedge arstn) begin
    if (!arstn) begin
      dout_lo <= '0;
      dout_hi <= '0;
    end else if (dinA <= dinB) begin
      dout_lo <= dinA;
      dout_hi <= dinB;
    end else begin
      dout_lo <= dinB;
      dout_hi <= dinA;
    end
  end

endmodule

// File: rtl/rank_select_seq.sv
// k-th order statistic of an N-sample window using one shared
// compare-swap unit and odd-even transposition sort.
module rank_select_seq
  import osf_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int N          = 9,
  parameter int IDX_W      = 4
) (
  input  logic                  clk,
  input  logic                  arstn,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic [IDX_W-1:0]      rank,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  busy
);

  localparam int PE = pairs_even(N);
  localparam int PO = pairs_odd(N);
  localparam logic [IDX_W-1:0] LAST = IDX_W'(N - 1);
  localparam logic [IDX_W-1:0] PE_W = IDX_W'(PE);
  localparam logic [IDX_W-1:0] PO_W = IDX_W'(PO);

  state_e state_q, state_d;
  logic [IDX_W-1:0] cnt_q, cnt_d;
  logic [IDX_W-1:0] phase_q, phase_d;
  logic [IDX_W-1:0] pair_q, pair_d;
  logic [IDX_W-1:0] rank_q, rank_d;
  logic [IDX_W-1:0] wb_idx_q;
  logic             wb_pend_q;

  logic [DATA_WIDTH-1:0] arr_q [N];

  logic [IDX_W-1:0] idx, idx1, wb_idx1;
  logic [IDX_W-1:0] npairs, nxt_pairs;
  logic [DATA_WIDTH-1:0] cmp_lo, cmp_hi;
  logic in_fire;

  assign in_fire   = (state_q == LOAD) && in_valid;
  assign npairs    = phase_q[0] ? PO_W : PE_W;
  assign nxt_pairs = phase_q[0] ? PE_W : PO_W;
  // Odd phases shift the pairing by one element.
  assign idx       = (pair_q << 1) | IDX_W'(phase_q[0]);
  assign idx1      = idx + 1'b1;
  assign wb_idx1   = wb_idx_q + 1'b1;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    phase_d = phase_q;
    pair_d  = pair_q;
    rank_d  = rank_q;
    unique case (state_q)
      LOAD: begin
        if (in_valid) begin
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == '0) begin
            rank_d = (rank > LAST) ? LAST : rank;
          end
          if (cnt_q == LAST) begin
            state_d = SORT;
            cnt_d   = '0;
            phase_d = '0;
            pair_d  = '0;
          end
        end
      end
      SORT: begin
        if (pair_q + 1'b1 == npairs) begin
          state_d = DRAIN;
          pair_d  = '0;
        end else begin
          pair_d = pair_q + 1'b1;
        end
      end
      DRAIN: begin
        if (phase_q == LAST) begin
          state_d = OUT;
        end else begin
          phase_d = phase_q + 1'b1;
          // An empty phase only costs its drain cycle.
          state_d = (nxt_pairs == '0) ? DRAIN : SORT;
        end
      end
      OUT: begin
        if (out_ready) begin
          state_d = LOAD;
          cnt_d   = '0;
        end
      end
      default: state_d = LOAD;
    endcase
  end

  always_ff @(posedge clk or negedge arstn) begin
    if (!arstn) begin
      state_q   <= LOAD;
      cnt_q     <= '0;
      phase_q   <= '0;
      pair_q    <= '0;
      rank_q    <= '0;
      wb_idx_q  <= '0;
      wb_pend_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      phase_q   <= phase_d;
      pair_q    <= pair_d;
      rank_q    <= rank_d;
      wb_idx_q  <= idx;
      wb_pend_q <= (state_q == SORT);
    end
  end

  always_ff @(posedge clk or negedge arstn) begin
    if (!arstn) begin
      for (int i = 0; i < N; i++) arr_q[i] <= '0;
    end else begin
      if (in_fire) arr_q[cnt_q] <= in_data;
      if (wb_pend_q) begin
        arr_q[wb_idx_q] <= cmp_lo;
        arr_q[wb_idx1]  <= cmp_hi;
      end
    end
  end

  comparer2 #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_cmp (
    .clk    (clk),
    .arstn  (arstn),
    .dinA   (arr_q[idx]),
    .dinB   (arr_q[idx1]),
    .dout_lo(cmp_lo),
    .dout_hi(cmp_hi)
  );

  assign in_ready  = (state_q == LOAD);
  assign out_valid = (state_q == OUT);
  assign busy      = (state_q != LOAD);
  assign out_data  = out_valid ? arr_q[rank_q] : '0;

endmodule

// File: tb/tb_rank_select_seq.sv
// Bench for rank_select_seq: window table with a result scoreboard,
// plus backpressure, gap and mid-sort reset sequences.
module tb_rank_select_seq;

  typedef logic [8:0][7:0] win_t;

  typedef struct packed {
    win_t       s;
    logic [3:0] r;
    logic [7:0] exp;
    logic       gap;
    logic [3:0] hold;
  } vec_t;

  localparam int LAT = 45;

  logic       clk = 1'b0;
  logic       arstn = 1'b0;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [7:0] in_data = '0;
  logic [3:0] rank = '0;
  logic       out_valid;
  logic       out_ready = 1'b0;
  logic [7:0] out_data;
  logic       busy;

  int n_chk = 0;
  int n_pass = 0;
  int cyc = 0;
  int acc_cyc = 0;
  logic [7:0] sb[$];
  vec_t tbl[8];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  rank_select_seq #(
    .DATA_WIDTH(8),
    .N(9),
    .IDX_W(4)
  ) dut (
    .clk      (clk),
    .arstn    (arstn),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (in_data),
    .rank     (rank),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out_data),
    .busy     (busy)
  );

  function automatic win_t w9(input logic [7:0] a0, a1, a2, a3,
                              a4, a5, a6, a7, a8);
    win_t w;
    w[0] = a0; w[1] = a1; w[2] = a2;
    w[3] = a3; w[4] = a4; w[5] = a5;
    w[6] = a6; w[7] = a7; w[8] = a8;
    return w;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d want %0d", nm, act, exp);
  endtask

  task automatic send(input vec_t v, input bit push);
    int t;
    for (int i = 0; i < 9; i++) begin
      @(negedge clk);
      if (v.gap) @(negedge clk);
      in_valid = 1'b1;
      in_data  = v.s[i];
      rank     = (i == 0) ? v.r : 4'hF;
      t = 0;
      while (!in_ready && t < 100) begin
        @(negedge clk);
        t++;
      end
      if (t == 100) chk("in_ready_timeout", 0, 1);
      @(posedge clk);
      #1;
      in_valid = 1'b0;
    end
    acc_cyc = cyc;
    if (push) sb.push_back(v.exp);
  endtask

  task automatic recv(input int hold);
    int t;
    bit bad_busy, bad_rdy, bad_hold;
    logic [7:0] d0, e;
    t = 0;
    bad_busy = 0;
    bad_rdy = 0;
    bad_hold = 0;
    while (t < 200) begin
      @(negedge clk);
      if (out_valid) break;
      if (!busy) bad_busy = 1;
      if (in_ready) bad_rdy = 1;
      t++;
    end
    if (!out_valid) begin
      chk("out_valid_timeout", 0, 1);
      return;
    end
    chk("latency", cyc - acc_cyc, LAT);
    chk("busy_sort", bad_busy, 0);
    chk("in_ready_sort", bad_rdy, 0);
    chk("busy_out", busy, 1);
    chk("in_ready_out", in_ready, 0);
    d0 = out_data;
    if (sb.size() == 0) begin
      chk("sb_underflow", 0, 1);
    end else begin
      e = sb.pop_front();
      chk("out_data", d0, e);
    end
    if (hold > 0) begin
      in_valid = 1'b1;
      in_data  = 8'hAA;
      for (int k = 0; k < hold; k++) begin
        @(negedge clk);
        if (!out_valid || out_data !== d0 || in_ready) bad_hold = 1;
      end
      in_valid = 1'b0;
      chk("hold_stable", bad_hold, 0);
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    @(negedge clk);
    chk("in_ready_after", in_ready, 1);
    chk("out_valid_after", out_valid, 0);
    chk("out_data_idle", out_data, 0);
  endtask

  initial begin
    tbl[0] = '{s: w9(5, 3, 8, 1, 9, 2, 7, 4, 6), r: 4,
               exp: 5, gap: 0, hold: 0};
    tbl[1] = '{s: w9(5, 3, 8, 1, 9, 2, 7, 4, 6), r: 0,
               exp: 1, gap: 0, hold: 0};
    tbl[2] = '{s: w9(5, 3, 8, 1, 9, 2, 7, 4, 6), r: 8,
               exp: 9, gap: 0, hold: 0};
    tbl[3] = '{s: w9(7, 7, 7, 7, 7, 7, 7, 7, 7), r: 3,
               exp: 7, gap: 0, hold: 0};
    tbl[4] = '{s: w9(10, 11, 12, 13, 14, 15, 16, 17, 18), r: 12,
               exp: 18, gap: 0, hold: 0};
    tbl[5] = '{s: w9(5, 3, 8, 1, 9, 2, 7, 4, 6), r: 4,
               exp: 5, gap: 1, hold: 0};
    tbl[6] = '{s: w9(200, 0, 255, 17, 17, 90, 3, 128, 64), r: 5,
               exp: 90, gap: 0, hold: 10};
    tbl[7] = '{s: w9(9, 8, 7, 6, 5, 4, 3, 2, 1), r: 2,
               exp: 3, gap: 0, hold: 0};

    @(negedge clk);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_out_data", out_data, 0);
    @(negedge clk);
    arstn = 1'b1;

    for (int i = 0; i < 8; i++) begin
      send(tbl[i], 1'b1);
      recv(int'(tbl[i].hold));
    end

    send(tbl[0], 1'b0);
    repeat (22) @(posedge clk);
    #1;
    chk("pre_rst_busy", busy, 1);
    arstn = 1'b0;
    #1;
    chk("arst_out_valid", out_valid, 0);
    chk("arst_in_ready", in_ready, 1);
    chk("arst_out_data", out_data, 0);
    chk("arst_busy", busy, 0);
    @(negedge clk);
    arstn = 1'b1;
    send(tbl[7], 1'b1);
    recv(0);
    send(tbl[0], 1'b1);
    recv(0);

    chk("sb_empty", sb.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
